// File: rtl/adc_pkg.sv
// adc_pkg: shared state encoding, default sizes and log2 helper for the ADC capture and storage stages.
package adc_pkg;
  localparam int DATA_W_DEF = 12;
  localparam int NUM_WORDS_DEF = 4;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/adc_frame_capture_if.sv
// adc_frame_capture_if: valid/ready word stream from the capture stage to the storage stage.
interface adc_frame_capture_if #(
  parameter int DATA_W = 12
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;
  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/adc_word_ram.sv
// adc_word_ram: NUM_WORDS x DATA_W register array, one synchronous write port, one combinational read port.
module adc_word_ram
  import adc_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int ADDR_W    = log2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [NUM_WORDS];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/adc_frame_capture.sv
// adc_frame_capture: on arm, captures one NUM_WORDS frame of strobed ADC samples, then drains it over valid/ready.
module adc_frame_capture
  import adc_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int ADDR_W    = log2(NUM_WORDS),
  parameter int OVR_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm,
  input  logic                       abort,
  input  logic                       adc_strobe,
  input  logic [DATA_W-1:0]          adc_data,
  adc_frame_capture_if.master        out,
  output logic                       busy,
  output logic                       done,
  output logic [OVR_W-1:0]           overrun_cnt
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
  state_t            state, state_n;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rdata;
  logic              we, valid, last, beat, last_beat, frame_full, drop;
  adc_word_ram #(
    .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W)
  ) u_ram (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(wr_ptr), .wdata(adc_data),
    .raddr(rd_ptr), .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // abort outranks every other event, including the write and the final beat
  always_comb begin
    we         = state == CAPTURE && adc_strobe && !abort;
    frame_full = we && wr_ptr == LAST;
    valid      = state == DRAIN;
    last       = valid && rd_ptr == LAST;
    beat       = valid && out.ready && !abort;
    last_beat  = beat && last;
    drop       = valid && adc_strobe && !abort && overrun_cnt != '1;
    busy       = state != IDLE;
    out.valid  = valid;
    out.last   = last;
    out.data   = valid ? rdata : '0;
    state_n    = abort                  ? IDLE :
                 state == IDLE && arm   ? CAPTURE :
                 frame_full             ? DRAIN :
                 last_beat              ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      done        <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      done        <= last_beat;
      wr_ptr      <= abort || state == IDLE ? '0 : we ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr      <= abort || !valid ? '0 : beat ? rd_ptr + 1'b1 : rd_ptr;
      overrun_cnt <= drop ? overrun_cnt + 1'b1 : overrun_cnt;
    end
  end
endmodule
